// File: rtl/mem_interface.sv
// Memory interface: MAR/MDR registers plus a request/acknowledge handshake FSM
// with a 15-cycle timeout that flags a sticky error and returns zero read data.
module mem_interface (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Buss,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memEN,
    input  logic        memWE,
    input  logic [15:0] memRdata,
    input  logic        memAck,
    output logic [15:0] mdrOut,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata,
    output logic        memReq,
    output logic        memWr,
    output logic        memR,
    output logic        memErr,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } stateT;

    localparam logic [3:0] WaitLimit = 4'd14;

    stateT       state;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] rdBuf;
    logic        wrFlag;
    logic [3:0]  waitCnt;

    assign busy     = (state != StIdle);
    assign memReq   = (state == StReq);
    assign memR     = (state == StDone);
    assign memWr    = (state == StReq) && wrFlag;
    assign memAddr  = mar;
    assign memWdata = mdr;
    assign mdrOut   = mdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            mar     <= 16'h0000;
            mdr     <= 16'h0000;
            rdBuf   <= 16'h0000;
            wrFlag  <= 1'b0;
            waitCnt <= 4'd0;
            memErr  <= 1'b0;
        end else begin
            // Bus-sourced loads are locked out during an access; the read buffer path is not.
            if (ldMAR && !busy) begin
                mar <= Buss;
            end
            if (ldMDR) begin
                if (selMDR) begin
                    mdr <= rdBuf;
                end else if (!busy) begin
                    mdr <= Buss;
                end
            end

            unique case (state)
                StIdle: begin
                    if (memEN) begin
                        state   <= StReq;
                        wrFlag  <= memWE;
                        waitCnt <= 4'd0;
                        memErr  <= 1'b0;
                    end
                end
                StReq: begin
                    if (memAck) begin
                        state <= StDone;
                        if (!wrFlag) begin
                            rdBuf <= memRdata;
                        end
                    end else begin
                        waitCnt <= waitCnt + 4'd1;
                        if (waitCnt == WaitLimit) begin
                            state  <= StDone;
                            memErr <= 1'b1;
                            rdBuf  <= 16'h0000;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_interface.sv
// Directed bench for mem_interface: a vector table for single-cycle behaviour plus
// hand-written timeout and asynchronous-reset sequences.
module tb_mem_interface;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Buss = 16'h0000;
    logic        ldMAR = 1'b0;
    logic        ldMDR = 1'b0;
    logic        selMDR = 1'b0;
    logic        memEN = 1'b0;
    logic        memWE = 1'b0;
    logic [15:0] memRdata = 16'h0000;
    logic        memAck = 1'b0;
    logic [15:0] mdrOut;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic        memReq;
    logic        memWr;
    logic        memR;
    logic        memErr;
    logic        busy;

    int nVec = 0;
    int nErr = 0;

    mem_interface dut (
        .clk      (clk),
        .rst      (rst),
        .Buss     (Buss),
        .ldMAR    (ldMAR),
        .ldMDR    (ldMDR),
        .selMDR   (selMDR),
        .memEN    (memEN),
        .memWE    (memWE),
        .memRdata (memRdata),
        .memAck   (memAck),
        .mdrOut   (mdrOut),
        .memAddr  (memAddr),
        .memWdata (memWdata),
        .memReq   (memReq),
        .memWr    (memWr),
        .memR     (memR),
        .memErr   (memErr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ldMAR;
        logic        ldMDR;
        logic        selMDR;
        logic        memEN;
        logic        memWE;
        logic        memAck;
        logic [15:0] buss;
        logic [15:0] rdata;
        logic        req;
        logic        wr;
        logic        r;
        logic        bsy;
        logic [15:0] mdr;
        logic [15:0] addr;
    } vecT;

    vecT vq[$];

    function automatic vecT mk(input logic lm, input logic ld, input logic sel, input logic en,
                               input logic we, input logic ack, input logic [15:0] b,
                               input logic [15:0] rd, input logic req, input logic wr,
                               input logic r, input logic bsy, input logic [15:0] mdr,
                               input logic [15:0] addr);
        vecT v;
        v.ldMAR = lm; v.ldMDR = ld; v.selMDR = sel; v.memEN = en; v.memWE = we;
        v.memAck = ack; v.buss = b; v.rdata = rd;
        v.req = req; v.wr = wr; v.r = r; v.bsy = bsy; v.mdr = mdr; v.addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        ldMAR = 1'b0; ldMDR = 1'b0; selMDR = 1'b0; memEN = 1'b0; memWE = 1'b0;
        memAck = 1'b0; Buss = 16'h0000; memRdata = 16'h0000;
    endtask

    // Packs outputs as {req, wr, r, err, busy, mdrOut, memWdata, memAddr}.
    function automatic logic [63:0] outs();
        return {11'd0, memReq, memWr, memR, memErr, busy, mdrOut, memWdata, memAddr};
    endfunction

    initial begin
        int cnt;
        int rPulses;

        //             lm ld sl en we ak buss      rdata     rq wr r  by mdr       addr
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 16'h3010, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h3010));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h3010));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'hBEEF, 0, 0, 1, 1, 16'h0000, 16'h3010));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'hBEEF, 16'h3010));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 16'h4000, 16'h0000, 0, 0, 0, 0, 16'hBEEF, 16'h4000));
        vq.push_back(mk(0, 1, 0, 0, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h4000));
        vq.push_back(mk(0, 0, 0, 1, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234, 16'h4000));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234, 16'h4000));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234, 16'h4000));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 16'h1234, 16'h4000));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'hDEAD, 0, 0, 1, 1, 16'h1234, 16'h4000));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h4000));
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 16'h3010, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h3010));
        vq.push_back(mk(0, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h1234, 16'h3010));
        vq.push_back(mk(1, 1, 0, 1, 1, 0, 16'hFFFF, 16'h0000, 1, 0, 0, 1, 16'h1234, 16'h3010));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h5A5A, 0, 0, 1, 1, 16'h1234, 16'h3010));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h1234, 16'h3010));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h9999, 0, 0, 0, 0, 16'h1234, 16'h3010));
        vq.push_back(mk(1, 1, 0, 1, 1, 0, 16'h7777, 16'h0000, 1, 1, 0, 1, 16'h7777, 16'h7777));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 0, 0, 1, 1, 16'h7777, 16'h7777));
        vq.push_back(mk(0, 1, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h5A5A, 16'h7777));

        // Reset state, held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_release", outs(), 64'd0);

        foreach (vq[i]) begin
            ldMAR = vq[i].ldMAR; ldMDR = vq[i].ldMDR; selMDR = vq[i].selMDR;
            memEN = vq[i].memEN; memWE = vq[i].memWE; memAck = vq[i].memAck;
            Buss = vq[i].buss; memRdata = vq[i].rdata;
            step();
            check($sformatf("vec%0d", i), outs(),
                  {11'd0, vq[i].req, vq[i].wr, vq[i].r, 1'b0, vq[i].bsy,
                   vq[i].mdr, vq[i].mdr, vq[i].addr});
        end
        idleInputs();

        // Timeout: read never acknowledged
        memEN = 1'b1; memWE = 1'b0;
        step();
        idleInputs();
        cnt = 0;
        while (memReq && cnt < 40) begin
            cnt++;
            step();
        end
        check("timeout_req_cycles", 64'(cnt), 64'd15);
        check("timeout_done", {62'd0, memR, memErr}, 64'b11);
        step();
        check("timeout_err_sticky", {62'd0, memErr, busy}, 64'b10);
        ldMDR = 1'b1; selMDR = 1'b1;
        step();
        idleInputs();
        check("timeout_rdbuf_zero", 64'(mdrOut), 64'h0000);
        memEN = 1'b1; memWE = 1'b0;
        step();
        idleInputs();
        check("err_cleared", {62'd0, memReq, memErr}, 64'b10);
        memAck = 1'b1; memRdata = 16'hCAFE;
        step();
        idleInputs();
        step();
        check("post_timeout_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of an access
        ldMAR = 1'b1; Buss = 16'h3010;
        step();
        idleInputs();
        memEN = 1'b1;
        step();
        idleInputs();
        check("pre_reset_req", {47'd0, memReq, memAddr}, {47'd0, 1'b1, 16'h3010});
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", outs(), 64'd0);
        #3;
        rst = 1'b0;
        memAck = 1'b1;
        rPulses = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (memR || busy) rPulses++;
        end
        idleInputs();
        check("late_ack_ignored", 64'(rPulses), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 Buss  input  16  datapath bus; carries the MARMux result or other bus sources.
REQ-004 ldMAR  input  1  load MAR from Buss.
REQ-005 ldMDR  input  1  load MDR.
REQ-006 selMDR  input  1  MDR source: 1 = memory read buffer, 0 = Buss.
REQ-007 memEN  input  1  start a memory access, one-cycle strobe from the control FSM.
REQ-008 memWE  input  1  access type, sampled with memEN: 1 = write, 0 = read.
REQ-009 memRdata  input  16  read data from the memory device.
REQ-010 memAck  input  1  device acknowledge, one or more cycles.
REQ-011 mdrOut  output  16  MDR contents, gated onto the bus by the datapath.
REQ-012 memAddr  output  16  device address (MAR).
REQ-013 memWdata  output  16  device write data (MDR).
REQ-014 memReq  output  1  device request.
REQ-015 memWr  output  1  device write enable, valid while memReq = 1.
REQ-016 memR  output  1  access-complete pulse to the control FSM.
REQ-017 memErr  output  1  timeout flag, sticky.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 States are IDLE, REQ and DONE, all registered; memReq = (state == REQ) and memR = (state == DONE).
- memAddr = MAR.
- memWdata = MDR.
- mdrOut = MDR.
REQ-020 MAR captures Buss on ldMAR = 1 only while busy = 0; ldMAR is ignored otherwise.
REQ-021 With ldMDR = 1 and selMDR = 0, MDR captures Buss only while busy = 0.
REQ-022 With ldMDR = 1 and selMDR = 1, MDR captures the read buffer in any state.
REQ-023 IDLE + memEN = 1 -> REQ:
- latch memWE into wrFlag;
- clear waitCnt (4-bit);
- clear memErr.
memEN outside IDLE is ignored.
REQ-024 memWr = wrFlag while in REQ, else 0.
REQ-025 REQ + memAck = 1 at an edge -> DONE:
- for a read, latch memRdata into the read buffer;
- for a write, leave the read buffer unchanged.
REQ-026 REQ + memAck = 0:
- waitCnt increments;
- if waitCnt == 14 at that edge: -> DONE, memErr <= 1, read buffer <= 16'h0000.
- Maximum REQ residency is 15 cycles.
REQ-027 DONE -> IDLE unconditionally, so memR is exactly one cycle wide.
REQ-028 Minimum latency: memEN sampled at edge k, memReq high after k, memAck sampled at edge k+1, memR high for the cycle after edge k+1, IDLE after k+2.
REQ-029 memAck outside REQ is ignored and has no state effect.
REQ-030 ldMAR, ldMDR and memEN all asserted in the same IDLE cycle:
- registers load at that edge;
- the access uses the old MAR/MDR for that cycle, and the new values from the next cycle onward, since memAddr/memWdata are read only in REQ.
REQ-031 Back-to-back: memEN in the DONE cycle is ignored; a new access may start in the cycle after DONE.

Reset
REQ-032 rst = 1 immediately, regardless of clk, forces:
- state = IDLE;
- MAR, MDR, read buffer = 16'h0000;
- wrFlag = 0, waitCnt = 0, memErr = 0.
REQ-033 During and after reset: memReq = 0, memWr = 0, memR = 0, busy = 0, mdrOut = 16'h0000, memAddr = 16'h0000.
REQ-034 Reset asserted mid-access (REQ or DONE) aborts the access with no memR pulse; a late memAck afterwards is ignored.

Verification
REQ-035 Read: Buss = 16'h3010 with ldMAR, then memEN with memWE = 0, memAck at the next edge with memRdata = 16'hBEEF, then ldMDR with selMDR = 1 in the DONE cycle -> memAddr = 16'h3010, one-cycle memR, MDR = 16'hBEEF, memErr = 0.
REQ-036 Write: MAR = 16'h4000, MDR loaded from Buss = 16'h1234, memEN with memWE = 1, memAck after 3 wait cycles -> memWr = 1 and memWdata = 16'h1234 for 4 cycles of memReq, memR 1 cycle, MDR unchanged.
REQ-037 Timeout: read with memAck held 0 -> memReq high exactly 15 cycles, then memR 1 cycle with memErr = 1, read buffer 16'h0000; the next memEN clears memErr.
REQ-038 Busy lockout: during REQ, ldMAR with Buss = 16'hFFFF, ldMDR/selMDR = 0, and a second memEN -> MAR, MDR and state unaffected; exactly one memR.
REQ-039 Async reset: assert rst between edges while in REQ with MAR = 16'h3010 -> all outputs 0 immediately; memAck = 1 after release produces no memR.
